zx_uart_port: RTL and testbench
===============================

Name: zx_uart_port

Overview:
- I/O-port responder on the Z80 `cpu_bus`: answers CPU IN/OUT cycles and never initiates them.
- Exposes one 8N1 serial UART with TX/RX FIFOs to Spectrum software.
- Sits beside the other port decoders in the CPLD top level.
- Its `d_out`/`d_out_active` feed the top-level data-bus read mux.

Parameters:
- FIFO_DEPTH, 16, entries per FIFO; power of two, 2..64.
- DIV_RESET, 242, reset bit divisor (28 MHz / 115200 − 1).

Ports:
- clk28  input  1  system clock, 28 MHz
- rst_n  input  1  asynchronous active-low reset
- bus  interface  cpu_bus  CPU bus; uses a, d, iorq, m1, rd, wr and the one-cycle strobe ioreq; all signals active-high
- en  input  1  block enable; when 0, no decode and no side effects; the serial engines keep running
- d_out  output  8  read data
- d_out_active  output  1  this block drives the read mux
- uart_tx  output  1  serial out, idle high
- uart_rx  input  1  serial in, asynchronous

Behaviour:
- Decode: full 16-bit address match, and bus.iorq && !bus.m1 && en.
  - PORT_DATA 0x133B: write pushes a TX byte; read pops an RX byte.
  - PORT_STAT 0x143B: read returns status; write is ignored.
  - PORT_DIVL 0x153B: r/w divisor[7:0].
  - PORT_DIVH 0x163B: r/w divisor[13:8]; bits 7:6 read 0.
- Read data path:
  - d_out_active = decode && bus.rd, combinational.
  - d_out valid in the same cycle; no wait states.
- Side effects happen only in the cycle where bus.ioreq=1, so exactly once per CPU access.
  - A write samples bus.d in that cycle.
  - An RX pop takes effect after that cycle; the CPU sees the pre-pop head.
- Status byte:
  - bit0 RX not empty
  - bit1 TX FIFO full
  - bit2 RX overflow, sticky
  - bit3 TX busy (FIFO non-empty or shifter active)
  - bit4 framing error, sticky
  - bits 7:5 = 0
  - A status read with ioreq clears bits 2 and 4 after the read.
- Boundary cases:
  - Data read with RX empty returns 0xFF; no pop.
  - TX write with FIFO full: byte dropped; no flag.
  - RX byte completing while RX FIFO is full: byte dropped, overflow set.
  - CPU pop and engine push in the same cycle on a full FIFO: both succeed; count unchanged; no overflow.
- Divisor: 14 bits; bit time = divisor+1 clocks.
  - A write takes effect at the next bit boundary of each engine.
  - Divisor 0 is allowed (1 clock per bit).
- TX FSM:
  - States: IDLE → START → DATA(8 bits, LSB first) → STOP → IDLE.
  - Leaves IDLE the cycle after the FIFO is non-empty; the pop happens on IDLE→START.
  - Back-to-back bytes: STOP goes directly to START, with no idle gap.
- RX FSM:
  - uart_rx passes a 2-flop synchroniser.
  - IDLE: a falling edge starts the flow. START: wait (divisor>>1)+1 clocks; if the line is high, return to IDLE (glitch).
  - DATA: sample 8 bits at bit centres. STOP: sample once.
    - Stop bit high: push the byte.
    - Stop bit low: discard the byte, set framing error, and wait for the line to go high before returning to IDLE.
- Reset values (asynchronous):
  - FIFOs empty, flags 0, divisor = DIV_RESET.
  - uart_tx = 1, d_out = 0xFF, both FSMs IDLE.
  - Reset mid-frame aborts immediately.
  - d_out_active stays combinational and is gated by en.

Optional Feature:
- Macro UART_FLOWCTL_EN.
- Defined:
  - Adds ports cts_n (input, 2-flop synchronised) and rts_n (output).
  - The TX FSM leaves IDLE only while cts_n=0; a byte in progress always completes.
  - rts_n = 1 when the RX FIFO holds ≥ FIFO_DEPTH−2 entries, else 0.
  - Status bit5 = synchronised cts_n.
- Undefined: no extra ports; TX starts unconditionally; status bit5 = 0.

Decomposition:
- Shared package common gains:
  - localparams for the four port addresses (PORT_UART_DATA, PORT_UART_STAT, PORT_UART_DIVL, PORT_UART_DIVH).
  - UART_DIV_115200 = 242.
- One sub-module, uart_fifo:
  - synchronous FIFO with a DEPTH parameter;
  - push/pop/full/empty/count and first-word-fall-through head;
  - instantiated twice (TX and RX).
- TX and RX FSMs stay in zx_uart_port.

Test Plan:
- Reset, then read 0x143B and 0x153B → 0x00 and 0xF2; uart_tx=1.
- Set divisor 3 (writes 0x153B=0x03, 0x163B=0x00), OUT 0x133B,0xA5 → on uart_tx, low 4 clocks, then bits 1,0,1,0,0,1,0,1 at 4 clocks each, then high; status bit3 clears afterwards.
- Drive 0x3C serially on uart_rx at divisor 3 → status bit0=1; IN 0x133B returns 0x3C; second IN returns 0xFF; bit0=0.
- Send 17 bytes into RX with FIFO_DEPTH=16 → status bits0,2 set; 16 bytes read back in order; next status read shows bit2=0.
- RX frame with stop bit low → no push, status bit4=1; a following valid frame 0x55 is received correctly.
- Hold bus.ioreq for OUT 0x133B for several cycles and assert rst_n low mid-frame → exactly one push per access; reset forces uart_tx=1 and empties the FIFOs at once.

Source files
------------

// File: rtl/common_pkg.sv
// common: port map, defaults and FSM state types shared by the CPLD port decoders.
// Holds the UART I/O addresses, its reset bit divisor and the UART engine states.
package common;

    localparam logic [15:0] PORT_UART_DATA = 16'h133B;
    localparam logic [15:0] PORT_UART_STAT = 16'h143B;
    localparam logic [15:0] PORT_UART_DIVL = 16'h153B;
    localparam logic [15:0] PORT_UART_DIVH = 16'h163B;

    localparam int UART_DIV_115200 = 242;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAITHI
    } rx_state_t;

endpackage

// File: rtl/cpu_bus.sv
// cpu_bus: Z80 bus bundle seen by the CPLD port decoders.
// ioreq is a one-cycle strobe per I/O access; everything is active-high.
interface cpu_bus;

    logic [15:0] a;
    logic [7:0]  d;
    logic        iorq;
    logic        m1;
    logic        rd;
    logic        wr;
    logic        ioreq;

    modport dev (input a, d, iorq, m1, rd, wr, ioreq);
    modport cpu (output a, d, iorq, m1, rd, wr, ioreq);

endinterface

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous byte FIFO with first-word-fall-through head.
// A pop and a push in the same cycle both succeed even when full.
module uart_fifo #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic [7:0]  din,
    input  logic        pop,
    output logic [7:0]  head,
    output logic        full,
    output logic        empty,
    output logic [AW:0] count
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rp];

    // storage array; contents need no reset since empty hides the head
    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end

    // pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/zx_uart_port.sv
// zx_uart_port: Z80 I/O-port 8N1 UART with TX/RX FIFOs on ports 0x133B-0x163B.
// Define UART_FLOWCTL_EN to add cts_n/rts_n hardware flow control.
module zx_uart_port
    import common::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_RESET  = UART_DIV_115200
) (
    input  logic       clk28,
    input  logic       rst_n,
    cpu_bus.dev        bus,
    input  logic       en,
    output logic [7:0] d_out,
    output logic       d_out_active,
    output logic       uart_tx,
`ifdef UART_FLOWCTL_EN
    input  logic       cts_n,
    output logic       rts_n,
`endif
    input  logic       uart_rx
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          sel;
    logic          hit_data;
    logic          hit_stat;
    logic          hit_divl;
    logic          hit_divh;
    logic          wr_data;
    logic          wr_divl;
    logic          wr_divh;
    logic          rd_data;
    logic          rd_stat;
    logic [13:0]   div;
    logic          ovf;
    logic          ferr;
    logic [7:0]    status;
    logic          cts_ok;
    logic          stat_b5;

    logic          tx_full;
    logic          tx_empty;
    logic [7:0]    tx_head;
    logic [CW-1:0] tx_count;
    logic          tx_go;
    logic          tx_pop;
    logic          tx_busy;
    tx_state_t     tx_st;
    logic [13:0]   tx_cnt;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_sh;

    logic          rx_full;
    logic          rx_empty;
    logic [7:0]    rx_head;
    logic [CW-1:0] rx_count;
    logic          rx_pop;
    logic          rx_push;
    logic          rx_ferr;
    logic          rx_done;
    logic          rx_fall;
    logic          rx_s1;
    logic          rx_s2;
    logic          rx_prev;
    rx_state_t     rx_st;
    logic [13:0]   rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_sh;

    assign sel      = en && bus.iorq && !bus.m1;
    assign hit_data = sel && (bus.a == PORT_UART_DATA);
    assign hit_stat = sel && (bus.a == PORT_UART_STAT);
    assign hit_divl = sel && (bus.a == PORT_UART_DIVL);
    assign hit_divh = sel && (bus.a == PORT_UART_DIVH);

    assign d_out_active = (hit_data || hit_stat || hit_divl || hit_divh) && bus.rd;

    assign wr_data = hit_data && bus.ioreq && bus.wr;
    assign wr_divl = hit_divl && bus.ioreq && bus.wr;
    assign wr_divh = hit_divh && bus.ioreq && bus.wr;
    assign rd_data = hit_data && bus.ioreq && bus.rd;
    assign rd_stat = hit_stat && bus.ioreq && bus.rd;

    assign tx_busy = !tx_empty || (tx_st != TX_IDLE);
    assign status  = {2'b00, stat_b5, ferr, tx_busy, ovf, tx_full, !rx_empty};

`ifdef UART_FLOWCTL_EN
    logic cts_s1;
    logic cts_s2;

    // cts_n synchroniser; idles as "not clear"
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            cts_s1 <= 1'b1;
            cts_s2 <= 1'b1;
        end else begin
            cts_s1 <= cts_n;
            cts_s2 <= cts_s1;
        end
    end

    assign cts_ok  = !cts_s2;
    assign stat_b5 = cts_s2;
    assign rts_n   = (rx_count >= CW'(FIFO_DEPTH - 2));
`else
    assign cts_ok  = 1'b1;
    assign stat_b5 = 1'b0;
`endif

    logic unused_cnt;
    assign unused_cnt = ^{tx_count, rx_count};

    // read mux: pre-pop head is visible during the popping access
    always_comb begin
        d_out = 8'hFF;
        if (bus.rd) begin
            unique case (1'b1)
                hit_data: d_out = rx_empty ? 8'hFF : rx_head;
                hit_stat: d_out = status;
                hit_divl: d_out = div[7:0];
                hit_divh: d_out = {2'b00, div[13:8]};
                default:  d_out = 8'hFF;
            endcase
        end
    end

    uart_fifo #(.DEPTH(FIFO_DEPTH)) u_txq (
        .clk   (clk28),
        .rst_n (rst_n),
        .push  (wr_data),
        .din   (bus.d),
        .pop   (tx_pop),
        .head  (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    uart_fifo #(.DEPTH(FIFO_DEPTH)) u_rxq (
        .clk   (clk28),
        .rst_n (rst_n),
        .push  (rx_push),
        .din   (rx_sh),
        .pop   (rx_pop),
        .head  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    assign rx_pop = rd_data && !rx_empty;

    // divisor register and sticky error flags; a new event beats the clear
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            div  <= 14'(DIV_RESET);
            ovf  <= 1'b0;
            ferr <= 1'b0;
        end else begin
            if (wr_divl) div[7:0]  <= bus.d;
            if (wr_divh) div[13:8] <= bus.d[5:0];
            if (rx_push && rx_full && !rx_pop) ovf <= 1'b1;
            else if (rd_stat)                  ovf <= 1'b0;
            if (rx_ferr)      ferr <= 1'b0 | 1'b1;
            else if (rd_stat) ferr <= 1'b0;
        end
    end

    assign tx_go  = !tx_empty && cts_ok;
    assign tx_pop = tx_go && ((tx_st == TX_IDLE) ||
                              (tx_st == TX_STOP && tx_cnt == '0));

    // TX engine; divisor reloads at every bit boundary
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            tx_st   <= TX_IDLE;
            tx_cnt  <= '0;
            tx_bit  <= '0;
            tx_sh   <= '0;
            uart_tx <= 1'b1;
        end else begin
            unique case (tx_st)
                TX_IDLE: begin
                    if (tx_go) begin
                        tx_st   <= TX_START;
                        tx_sh   <= tx_head;
                        tx_cnt  <= div;
                        uart_tx <= 1'b0;
                    end
                end
                TX_START: begin
                    if (tx_cnt != '0) begin
                        tx_cnt <= tx_cnt - 14'd1;
                    end else begin
                        tx_st   <= TX_DATA;
                        tx_cnt  <= div;
                        tx_bit  <= '0;
                        uart_tx <= tx_sh[0];
                    end
                end
                TX_DATA: begin
                    if (tx_cnt != '0) begin
                        tx_cnt <= tx_cnt - 14'd1;
                    end else begin
                        tx_cnt <= div;
                        if (tx_bit == 3'd7) begin
                            tx_st   <= TX_STOP;
                            uart_tx <= 1'b1;
                        end else begin
                            tx_bit  <= tx_bit + 3'd1;
                            tx_sh   <= {1'b0, tx_sh[7:1]};
                            uart_tx <= tx_sh[1];
                        end
                    end
                end
                TX_STOP: begin
                    if (tx_cnt != '0) begin
                        tx_cnt <= tx_cnt - 14'd1;
                    end else if (tx_go) begin
                        tx_st   <= TX_START;
                        tx_sh   <= tx_head;
                        tx_cnt  <= div;
                        uart_tx <= 1'b0;
                    end else begin
                        tx_st <= TX_IDLE;
                    end
                end
                default: tx_st <= TX_IDLE;
            endcase
        end
    end

    // uart_rx synchroniser plus one delayed copy for edge detection
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= uart_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    assign rx_fall = rx_prev && !rx_s2;
    assign rx_done = (rx_st == RX_STOP) && (rx_cnt == '0);
    assign rx_push = rx_done && rx_s2;
    assign rx_ferr = rx_done && !rx_s2;

    // RX engine: half-bit to the start centre, then whole bits
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            rx_st  <= RX_IDLE;
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_sh  <= '0;
        end else begin
            unique case (rx_st)
                RX_IDLE: begin
                    if (rx_fall) begin
                        rx_st  <= RX_START;
                        rx_cnt <= {1'b0, div[13:1]};
                    end
                end
                RX_START: begin
                    if (rx_cnt != '0) begin
                        rx_cnt <= rx_cnt - 14'd1;
                    end else if (rx_s2) begin
                        rx_st <= RX_IDLE;
                    end else begin
                        rx_st  <= RX_DATA;
                        rx_cnt <= div;
                        rx_bit <= '0;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt != '0) begin
                        rx_cnt <= rx_cnt - 14'd1;
                    end else begin
                        rx_sh  <= {rx_s2, rx_sh[7:1]};
                        rx_cnt <= div;
                        if (rx_bit == 3'd7) rx_st <= RX_STOP;
                        else                rx_bit <= rx_bit + 3'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt != '0)  rx_cnt <= rx_cnt - 14'd1;
                    else if (rx_s2)    rx_st  <= RX_IDLE;
                    else               rx_st  <= RX_WAITHI;
                end
                RX_WAITHI: begin
                    if (rx_s2) rx_st <= RX_IDLE;
                end
                default: rx_st <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_zx_uart_port.sv
// tb_zx_uart_port: randomized bench for the zx_uart_port I/O-port UART.
// Expected bytes, flags and serial waveforms come from queues and frame arithmetic.
module tb_zx_uart_port;

    import common::*;

    logic       clk28 = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b1;
    logic       uart_rx = 1'b1;
    logic [7:0] d_out;
    logic       d_out_active;
    logic       uart_tx;
`ifdef UART_FLOWCTL_EN
    logic       cts_n = 1'b0;
    logic       rts_n;
`endif

    cpu_bus bus_if ();

    zx_uart_port dut (
        .clk28        (clk28),
        .rst_n        (rst_n),
        .bus          (bus_if),
        .en           (en),
        .d_out        (d_out),
        .d_out_active (d_out_active),
        .uart_tx      (uart_tx),
`ifdef UART_FLOWCTL_EN
        .cts_n        (cts_n),
        .rts_n        (rts_n),
`endif
        .uart_rx      (uart_rx)
    );

    always #5 clk28 = ~clk28;

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    bit         m_ovf  = 1'b0;
    bit         m_ferr = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic io_wr(input logic [15:0] a, input logic [7:0] d, input int hold);
        @(posedge clk28); #1;
        bus_if.a = a; bus_if.d = d;
        bus_if.iorq = 1'b1; bus_if.wr = 1'b1; bus_if.ioreq = 1'b1;
        @(posedge clk28); #1;
        bus_if.ioreq = 1'b0;
        for (int i = 1; i < hold; i++) begin
            @(posedge clk28); #1;
        end
        bus_if.iorq = 1'b0; bus_if.wr = 1'b0;
    endtask

    task automatic io_rd(input logic [15:0] a, output logic [7:0] d, output logic act);
        @(posedge clk28); #1;
        bus_if.a = a;
        bus_if.iorq = 1'b1; bus_if.rd = 1'b1; bus_if.ioreq = 1'b1;
        @(negedge clk28);
        d = d_out; act = d_out_active;
        @(posedge clk28); #1;
        bus_if.ioreq = 1'b0; bus_if.iorq = 1'b0; bus_if.rd = 1'b0;
    endtask

    function automatic logic [7:0] exp_stat(input bit busy, input bit full);
        return {3'b000, m_ferr, busy, m_ovf, full, rxq.size() != 0};
    endfunction

    task automatic rd_stat(input string tag, input bit busy, input bit full);
        logic [7:0] d;
        logic       act;
        logic [7:0] e;
        e = exp_stat(busy, full);
        io_rd(PORT_UART_STAT, d, act);
        chk(tag, 64'(d), 64'(e));
        m_ovf  = 1'b0;
        m_ferr = 1'b0;
    endtask

    task automatic rd_data(input string tag);
        logic [7:0] d;
        logic       act;
        logic [7:0] e;
        e = (rxq.size() != 0) ? rxq.pop_front() : 8'hFF;
        io_rd(PORT_UART_DATA, d, act);
        chk(tag, 64'(d), 64'(e));
    endtask

    task automatic send_rx(input logic [7:0] b, input bit stop, input int bt, input int gap);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        @(posedge clk28); #1;
        for (int i = 0; i < 10; i++) begin
            uart_rx = fr[i];
            repeat (bt) @(posedge clk28);
            #1;
        end
        if (!stop) begin
            repeat (2 * bt) @(posedge clk28);
            #1;
        end
        uart_rx = 1'b1;
        repeat (gap) @(posedge clk28);
        #1;
        if (!stop)                m_ferr = 1'b1;
        else if (rxq.size() < 16) rxq.push_back(b);
        else                      m_ovf = 1'b1;
    endtask

    task automatic cap_tx(input int bt, input int nb);
        int         w;
        logic [63:0] got;
        logic [63:0] exp;
        logic [9:0]  fr;
        w = 0;
        do begin
            @(negedge clk28);
            w++;
        end while (uart_tx !== 1'b0 && w < 400);
        chk("tx_start_seen", 64'(uart_tx), 64'd0);
        for (int k = 0; k < nb; k++) begin
            fr  = {1'b1, txq.pop_front(), 1'b0};
            got = '0;
            exp = '0;
            for (int i = 0; i < 10 * bt; i++) begin
                if (k != 0 || i != 0) @(negedge clk28);
                got[i] = uart_tx;
                exp[i] = fr[i / bt];
            end
            chk("tx_frame", got, exp);
        end
    endtask

    task automatic wr_bytes(input logic [7:0] bs[$], input int hold);
        foreach (bs[i]) io_wr(PORT_UART_DATA, bs[i], hold);
    endtask

    initial begin
        logic [7:0] d;
        logic       act;
        logic [7:0] bs[$];
        int         lows;
        int         hold;

        bus_if.a = '0; bus_if.d = '0; bus_if.iorq = 1'b0; bus_if.m1 = 1'b0;
        bus_if.rd = 1'b0; bus_if.wr = 1'b0; bus_if.ioreq = 1'b0;

        repeat (3) @(posedge clk28);
        #1;
        chk("rst_uart_tx", 64'(uart_tx), 64'd1);
        chk("rst_d_out", 64'(d_out), 64'hFF);
        chk("rst_d_out_active", 64'(d_out_active), 64'd0);
        rst_n = 1'b1;

        io_rd(PORT_UART_STAT, d, act);
        chk("rst_stat", 64'(d), 64'h00);
        chk("rd_active", 64'(act), 64'd1);
        io_rd(PORT_UART_DIVL, d, act);
        chk("rst_divl", 64'(d), 64'hF2);
        io_rd(PORT_UART_DIVH, d, act);
        chk("rst_divh", 64'(d), 64'h00);

        en = 1'b0;
        io_rd(PORT_UART_STAT, d, act);
        chk("en0_active", 64'(act), 64'd0);
        chk("en0_d_out", 64'(d), 64'hFF);
        io_wr(PORT_UART_DATA, 8'h77, 1);
        en = 1'b1;
        bus_if.m1 = 1'b1;
        io_rd(PORT_UART_STAT, d, act);
        chk("m1_active", 64'(act), 64'd0);
        bus_if.m1 = 1'b0;
        repeat (2) @(posedge clk28);
        rd_stat("en0_no_push", 1'b0, 1'b0);

        io_wr(PORT_UART_DIVH, 8'hC1, 1);
        io_rd(PORT_UART_DIVH, d, act);
        chk("divh_mask", 64'(d), 64'h01);
        io_wr(PORT_UART_DIVL, 8'h03, 1);
        io_wr(PORT_UART_DIVH, 8'h00, 1);
        io_rd(PORT_UART_DIVL, d, act);
        chk("divl_3", 64'(d), 64'h03);

        txq.push_back(8'hA5);
        fork
            io_wr(PORT_UART_DATA, 8'hA5, 1);
            cap_tx(4, 1);
        join
        repeat (2) @(posedge clk28);
        rd_stat("tx_a5_done", 1'b0, 1'b0);

        for (int r = 0; r < 3; r++) begin
            bs.delete();
            hold = $urandom_range(1, 4);
            for (int k = 0; k <= r; k++) begin
                bs.push_back(8'($urandom));
                txq.push_back(bs[k]);
            end
            fork
                wr_bytes(bs, hold);
                cap_tx(4, r + 1);
            join
            lows = 0;
            for (int i = 0; i < 60; i++) begin
                @(negedge clk28);
                if (uart_tx !== 1'b1) lows++;
            end
            chk("tx_idle_after", 64'(lows), 64'd0);
            rd_stat("tx_burst_done", 1'b0, 1'b0);
        end

        send_rx(8'h3C, 1'b1, 4, 3);
        rd_stat("rx_3c_stat", 1'b0, 1'b0);
        rd_data("rx_3c_data");
        rd_data("rx_empty_ff");
        rd_stat("rx_3c_empty", 1'b0, 1'b0);

        for (int k = 0; k < 3; k++) send_rx(8'($urandom), 1'b1, 4, $urandom_range(1, 5));
        for (int k = 0; k < 3; k++) rd_data("rx_rand_data");

        for (int k = 0; k < 17; k++) send_rx(8'($urandom), 1'b1, 4, $urandom_range(0, 3));
        repeat (3) @(posedge clk28);
        rd_stat("rx_ovf_stat", 1'b0, 1'b0);
        for (int k = 0; k < 16; k++) rd_data("rx_ovf_data");
        rd_stat("rx_ovf_clear", 1'b0, 1'b0);

        send_rx(8'h99, 1'b0, 4, 4);
        rd_stat("rx_ferr_stat", 1'b0, 1'b0);
        send_rx(8'h55, 1'b1, 4, 3);
        rd_data("rx_after_ferr");
        rd_stat("rx_ferr_clear", 1'b0, 1'b0);

        send_rx(8'($urandom), 1'b1, 4, 3);
        io_wr(PORT_UART_DIVL, 8'hC8, 1);
        io_wr(PORT_UART_DIVH, 8'h01, 1);
        for (int k = 0; k < 18; k++) io_wr(PORT_UART_DATA, 8'($urandom), 1);
        rd_stat("tx_full_stat", 1'b1, 1'b1);
        @(negedge clk28);
        chk("tx_midframe", 64'(uart_tx), 64'd0);

        @(posedge clk28); #3;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_tx", 64'(uart_tx), 64'd1);
        bus_if.a = PORT_UART_STAT; bus_if.iorq = 1'b1; bus_if.rd = 1'b1;
        #1;
        chk("rst_mid_stat", 64'(d_out), 64'h00);
        bus_if.iorq = 1'b0; bus_if.rd = 1'b0;
        rxq.delete();
        m_ovf = 1'b0;
        m_ferr = 1'b0;
        repeat (2) @(posedge clk28);
        #2;
        rst_n = 1'b1;

        io_rd(PORT_UART_DIVL, d, act);
        chk("rst2_divl", 64'(d), 64'hF2);
        io_rd(PORT_UART_DIVH, d, act);
        chk("rst2_divh", 64'(d), 64'h00);
        rd_data("rst2_data");
        rd_stat("rst2_stat", 1'b0, 1'b0);
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk28);
            if (uart_tx !== 1'b1) lows++;
        end
        chk("rst2_tx_idle", 64'(lows), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
